// File: rtl/fwd_unit.sv
// fwd_unit: EX/MEM/WB tag pipeline producing registered operand-forward selects and a load-use stall.
// Optional statistics counters are enabled by defining FWD_UNIT_STATS_EN.
`default_nettype none

module fwd_unit #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall,
`ifdef FWD_UNIT_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt,
`endif
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel
);

  localparam logic [SEL_W-1:0] C_SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] C_SEL_EX  = SEL_W'(1);
  localparam logic [SEL_W-1:0] C_SEL_MEM = SEL_W'(2);
  localparam logic [SEL_W-1:0] C_SEL_WB  = SEL_W'(3);

  logic              r_ex_valid, r_mem_valid, r_wb_valid;
  logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
  logic              r_ex_rw, r_mem_rw, r_wb_rw;
  logic              r_ex_mr, r_mem_mr, r_wb_mr;
  logic [SEL_W-1:0]  r_a_sel, r_b_sel;

  logic              w_ex_prod, w_mem_prod, w_wb_prod;
  logic              w_load;
  logic [SEL_W-1:0]  w_a_nxt, w_b_nxt;

  // A tag only forwards if it really writes a non-zero register.
  assign w_ex_prod  = r_ex_valid  && r_ex_rw  && (r_ex_rd  != '0);
  assign w_mem_prod = r_mem_valid && r_mem_rw && (r_mem_rd != '0);
  assign w_wb_prod  = r_wb_valid  && r_wb_rw  && (r_wb_rd  != '0);

  assign stall  = id_valid && !flush && w_ex_prod && r_ex_mr &&
                  ((r_ex_rd == id_rs) || (r_ex_rd == id_rt));
  assign w_load = id_valid && !stall && !flush;

  function automatic logic [SEL_W-1:0] pick_sel(
    input logic              load,
    input logic [REG_AW-1:0] idx,
    input logic              ex_p,
    input logic [REG_AW-1:0] ex_rd,
    input logic              mem_p,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_p,
    input logic [REG_AW-1:0] wb_rd
  );
    logic [SEL_W-1:0] s;
    s = C_SEL_RF;
    if (load) begin
      if (ex_p && (ex_rd == idx))        s = C_SEL_EX;
      else if (mem_p && (mem_rd == idx)) s = C_SEL_MEM;
      else if (wb_p && (wb_rd == idx))   s = C_SEL_WB;
    end
    return s;
  endfunction

  assign w_a_nxt = pick_sel(w_load, id_rs, w_ex_prod, r_ex_rd, w_mem_prod, r_mem_rd,
                            w_wb_prod, r_wb_rd);
  assign w_b_nxt = pick_sel(w_load, id_rt, w_ex_prod, r_ex_rd, w_mem_prod, r_mem_rd,
                            w_wb_prod, r_wb_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= '0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_rw    <= 1'b0;
      r_mem_mr    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_rw     <= 1'b0;
      r_wb_mr     <= 1'b0;
      r_a_sel     <= C_SEL_RF;
      r_b_sel     <= C_SEL_RF;
    end else begin
      r_wb_valid  <= r_mem_valid;
      r_wb_rd     <= r_mem_rd;
      r_wb_rw     <= r_mem_rw;
      r_wb_mr     <= r_mem_mr;
      r_mem_valid <= r_ex_valid;
      r_mem_rd    <= r_ex_rd;
      r_mem_rw    <= r_ex_rw;
      r_mem_mr    <= r_ex_mr;
      r_ex_valid  <= w_load;
      r_ex_rd     <= w_load ? id_rd : '0;
      r_ex_rw     <= w_load && id_regwrite;
      r_ex_mr     <= w_load && id_memread;
      r_a_sel     <= w_a_nxt;
      r_b_sel     <= w_b_nxt;
    end
  end

  assign fwd_a_sel = r_a_sel;
  assign fwd_b_sel = r_b_sel;

`ifdef FWD_UNIT_STATS_EN
  logic [31:0] r_stall_cnt, r_fwd_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (((w_a_nxt != C_SEL_RF) || (w_b_nxt != C_SEL_RF)) && (r_fwd_cnt != 32'hFFFF_FFFF))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_unit.sv
// tb_fwd_unit: directed scenarios with a queue scoreboard of expected EX-stage selects.
`default_nettype none

module tb_fwd_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_regwrite, id_memread, flush;
  logic       stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef FWD_UNIT_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  fwd_unit #(.REG_AW(5), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall),
`ifdef FWD_UNIT_STATS_EN
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt),
`endif
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_a"}, {30'd0, fwd_a_sel}, {30'd0, e[3:2]});
      check_eq({tag, "_b"}, {30'd0, fwd_b_sel}, {30'd0, e[1:0]});
    end
  endtask

  // One ID cycle: drive, check stall mid-cycle, then check the selects registered at the edge.
  task automatic cyc(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                     input logic exp_st, input logic [1:0] ea, input logic [1:0] eb);
    drive(v, rs, rt, rd, rw, mr, fl);
    #4;
    check_eq({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_st});
    exp_q.push_back({ea, eb});
    @(posedge clk); #1;
    pop_check(tag);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(4'd0);
      @(posedge clk); #1;
      pop_check("nop");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(4'd0);
    pop_check("reset");
    check_eq("reset_stall", {31'd0, stall}, 32'd0);

    // EX->EX forwarding
    cyc("exex_w", 1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("exex_r", 1, 5'd3, 5'd0, 5'd20, 1, 0, 0, 0, 2'd1, 2'd0);
    nops(3);

    // distance 2 and 3
    cyc("d2_w", 1, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("d2_u", 1, 5'd8, 5'd9, 5'd10, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("d2_r", 1, 5'd11, 5'd5, 5'd0, 0, 0, 0, 0, 2'd0, 2'd2);
    nops(3);
    cyc("d3_w", 1, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("d3_u1", 1, 5'd8, 5'd9, 5'd10, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("d3_u2", 1, 5'd13, 5'd14, 5'd12, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("d3_r", 1, 5'd11, 5'd5, 5'd0, 0, 0, 0, 0, 2'd0, 2'd3);
    nops(3);

    // load-use: one stall cycle, bubble, then MEM forward
    cyc("lu_lw", 1, 5'd1, 5'd0, 5'd7, 1, 1, 0, 0, 2'd0, 2'd0);
    cyc("lu_st", 1, 5'd7, 5'd0, 5'd8, 1, 0, 0, 1, 2'd0, 2'd0);
    cyc("lu_r", 1, 5'd7, 5'd0, 5'd8, 1, 0, 0, 0, 2'd2, 2'd0);
    cyc("lu_n", 1, 5'd8, 5'd7, 5'd0, 0, 0, 0, 0, 2'd1, 2'd3);
`ifdef FWD_UNIT_STATS_EN
    check_eq("stall_cnt_lu", stall_cnt, 32'd1);
`endif
    nops(3);

    // priority, r0 and non-writing producer
    cyc("pr_w1", 1, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("pr_w2", 1, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("pr_r", 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0, 2'd1, 2'd1);
    cyc("r0_w", 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'd0, 2'd0);
    cyc("r0_r", 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc("nw_w", 1, 5'd0, 5'd0, 5'd6, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc("nw_r", 1, 5'd6, 5'd4, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
    nops(3);

    // flush beats a load-use hazard and the flushed instruction never reaches EX
    cyc("fl_lw", 1, 5'd0, 5'd0, 5'd2, 1, 1, 0, 0, 2'd0, 2'd0);
    cyc("fl_hz", 1, 5'd2, 5'd0, 5'd9, 1, 0, 1, 0, 2'd0, 2'd0);
    cyc("fl_nx", 1, 5'd9, 5'd2, 5'd0, 0, 0, 0, 0, 2'd0, 2'd2);
    nops(3);

    // reset while a load-use stall is pending
    cyc("rs_lw", 1, 5'd0, 5'd0, 5'd7, 1, 1, 0, 0, 2'd0, 2'd0);
    drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    #4;
    check_eq("rs_pre_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    exp_q.push_back(4'd0);
    @(posedge clk); #1;
    pop_check("rs_edge");
    check_eq("rs_stall", {31'd0, stall}, 32'd0);
`ifdef FWD_UNIT_STATS_EN
    check_eq("rs_stall_cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    cyc("rs_after", 1, 5'd7, 5'd0, 5'd8, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("rs_next", 1, 5'd8, 5'd7, 5'd0, 0, 0, 0, 0, 2'd1, 2'd0);
    nops(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
